// File: rtl/booth_divider_if.sv
// Start/done handshake bundle for the signed sequential divider.
// Master issues operands, slave returns quotient, remainder and flags.
interface booth_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder,
    input  div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder,
    output div_by_zero, overflow
  );
endinterface

// File: rtl/booth_divider.sv
// Signed restoring divider on operand magnitudes, one quotient bit per
// cycle; the inverse of the 4x4->8 booth multiplier.
module booth_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input logic           clk,
  input logic           rst,
  booth_divider_if.slave bus
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dq_q;
  logic [VW-1:0] pr_q;
  logic [VW-1:0] dv_q;
  logic          sgnq_q;
  logic          sgnr_q;
  logic          dz_q;
  logic          ov_q;

  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q;
  logic          dzo_q;
  logic          ovo_q;

  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  logic [VW:0]   sh;
  logic          qbit;
  logic [VW-1:0] pr_d;
  logic [DW-1:0] quo_d;
  logic [VW-1:0] rem_d;

  always_comb begin
    a_mag = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
    b_mag = bus.divisor[VW-1]  ? -bus.divisor  : bus.divisor;
    sh    = {pr_q, dq_q[DW-1]};
    qbit  = (sh >= {1'b0, dv_q});
    pr_d  = qbit ? VW'(sh - {1'b0, dv_q}) : sh[VW-1:0];
    quo_d = sgnq_q ? -dq_q : dq_q;
    rem_d = sgnr_q ? -pr_q : pr_q;
    // Divide by zero overrides whatever the iterations produced
    if (dz_q) begin
      quo_d = '1;
      rem_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      pr_q    <= '0;
      dv_q    <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (bus.start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            dq_q    <= a_mag;
            pr_q    <= '0;
            dv_q    <= b_mag;
            sgnq_q  <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
            sgnr_q  <= bus.dividend[DW-1];
            dz_q    <= (bus.divisor == '0);
            ov_q    <= (bus.dividend == {1'b1, {(DW-1){1'b0}}})
                       && (bus.divisor == '1);
          end
        end
        CALC: begin
          dq_q  <= {dq_q[DW-2:0], qbit};
          pr_q  <= pr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) state_q <= FIX;
        end
        FIX: begin
          quo_q   <= quo_d;
          rem_q   <= rem_d;
          dzo_q   <= dz_q;
          ovo_q   <= ov_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dzo_q;
  assign bus.overflow    = ovo_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed and exhaustive checks of the signed sequential divider.
// Latency is counted in falling edges after the accepting rising edge.
module tb_booth_divider;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  booth_divider_if #(.DW(8), .VW(4)) bus ();

  booth_divider #(.DW(8), .VW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 30);
  endtask

  task automatic chk_res(input string tag,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic edz, input logic eov);
    chk({tag, ".q"},  32'(bus.quotient),    32'(eq));
    chk({tag, ".r"},  32'(bus.remainder),   32'(er));
    chk({tag, ".dz"}, 32'(bus.div_by_zero), 32'(edz));
    chk({tag, ".ov"}, 32'(bus.overflow),    32'(eov));
  endtask

  task automatic check_op(input string tag,
                          input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er,
                          input logic edz, input logic eov);
    int n;
    launch(a, b);
    wait_done(n);
    chk({tag, ".lat"}, 32'(n), 32'd10);
    chk_res(tag, eq, er, edz, eov);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[9] = '{
    '{8'd100,  4'd7,   8'h0E, 4'h2, 1'b0, 1'b0},
    '{8'h9C,   4'd7,   8'hF2, 4'hE, 1'b0, 1'b0},
    '{8'd100,  4'h8,   8'hF4, 4'h4, 1'b0, 1'b0},
    '{8'h9C,   4'h8,   8'h0C, 4'hC, 1'b0, 1'b0},
    '{8'h80,   4'hF,   8'h80, 4'h0, 1'b0, 1'b1},
    '{8'd5,    4'd0,   8'hFF, 4'h0, 1'b1, 1'b0},
    '{8'd7,    4'd7,   8'h01, 4'h0, 1'b0, 1'b0},
    '{8'hFF,   4'd7,   8'h00, 4'hF, 1'b0, 1'b0},
    '{8'd127,  4'h8,   8'hF1, 4'h7, 1'b0, 1'b0}
  };

  initial begin
    int n;
    int dcnt;
    int sa, sb;
    logic [7:0] eq;
    logic [3:0] er;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk_res("rst", 8'h00, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i])
      check_op($sformatf("dir%0d", i), vecs[i].a, vecs[i].b,
               vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);

    // Reset during the 4th busy cycle aborts the division
    launch(8'd100, 4'd7);
    chk("abort.busy", 32'(bus.busy), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy0", 32'(bus.busy), 32'd0);
    chk("abort.done0", 32'(bus.done), 32'd0);
    chk_res("abort", 8'h00, 4'h0, 1'b0, 1'b0);
    rst  = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort.nodone", 32'(dcnt), 32'd0);
    check_op("after", 8'd20, 4'd3, 8'h06, 4'h2, 1'b0, 1'b0);

    // start held with new operands while in CALC must be ignored
    launch(8'd100, 4'd7);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start    = (n < 5);
      bus.dividend = 8'd50;
      bus.divisor  = 4'd3;
    end while (!bus.done && n < 30);
    bus.start = 1'b0;
    chk("ign.lat", 32'(n), 32'd10);
    chk_res("ign", 8'h0E, 4'h2, 1'b0, 1'b0);

    // start in the DONE cycle: accepted with no idle gap
    launch(8'd100, 4'd7);
    wait_done(n);
    chk("b2b.done", 32'(bus.done), 32'd1);
    bus.start    = 1'b1;
    bus.dividend = 8'h9C;
    bus.divisor  = 4'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("b2b.busy", 32'(bus.busy), 32'd1);
    chk("b2b.done0", 32'(bus.done), 32'd0);
    chk("b2b.hold", 32'(bus.quotient), 32'h0E);
    wait_done(n);
    chk("b2b.lat", 32'(n), 32'd10);
    chk_res("b2b", 8'hF2, 4'hE, 1'b0, 1'b0);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        sa = $signed(8'(a));
        sb = $signed(4'(b));
        if (sb == 0) begin
          eq = 8'hFF;
          er = 4'h0;
        end else begin
          eq = 8'(sa / sb);
          er = 4'(sa % sb);
        end
        check_op($sformatf("sw%0d_%0d", sa, sb), 8'(a), 4'(b), eq, er,
                 sb == 0, (sa == -128) && (sb == -1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
